// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one adder; one registered sum at a time.
// Define ADDER_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to requester 0.
module adder_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id
);
`ifdef ADDER_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic last_grant, gnt1, xfer;
  logic [WIDTH-1:0] op_a, op_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (xfer ? HOLD : IDLE) : (res_ready ? IDLE : HOLD);
  // A contested grant goes to requester 1 only when round-robin says it is its turn.
  always_comb begin
    gnt1       = req1_valid && (!req0_valid || (RR && !last_grant));
    req0_ready = rst_n && state == IDLE && req0_valid && !gnt1;
    req1_ready = rst_n && state == IDLE && gnt1;
    xfer       = req0_ready || req1_ready;
    res_valid  = state == HOLD;
    op_a       = gnt1 ? req1_a : req0_a;
    op_b       = gnt1 ? req1_b : req0_b;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_sum    <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      res_sum    <= {1'b0, op_a} + {1'b0, op_b};
      res_id     <= gnt1;
      last_grant <= gnt1;
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: table-driven directed vectors plus hand-written arbitration and async-reset sequences.
module tb_adder_arbiter;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic v0; logic [3:0] a0, b0;
    logic v1; logic [3:0] a1, b1;
    logic rr;
    logic r0, r1, rv; logic [4:0] sum; logic id;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid, req1_valid, req0_ready, req1_ready, res_valid, res_ready, res_id;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0] res_sum;
  int errors = 0, checks = 0;
  vec_t vec [16];
  adder_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  function automatic vec_t mk(input logic v0, input int a0, input int b0, input logic v1,
      input int a1, input int b1, input logic rr, input logic r0, input logic r1,
      input logic rv, input int sum, input logic id);
    vec_t v;
    v.v0 = v0; v.a0 = 4'(a0); v.b0 = 4'(b0);
    v.v1 = v1; v.a1 = 4'(a1); v.b1 = 4'(b1);
    v.rr = rr; v.r0 = r0; v.r1 = r1; v.rv = rv; v.sum = 5'(sum); v.id = id;
    return v;
  endfunction
  task automatic drive(input logic v0, input int a0, input int b0, input logic v1,
      input int a1, input int b1, input logic rr);
    req0_valid = v0; req0_a = 4'(a0); req0_b = 4'(b0);
    req1_valid = v1; req1_a = 4'(a1); req1_b = 4'(b1);
    res_ready = rr;
  endtask
  initial begin
    //            v0 a0 b0  v1 a1 b1  rr  r0   r1   rv  sum          id
    vec[0]  = mk(1, 7, 9,  0, 0, 0,  1,  1,   0,   0,  0,           0);
    vec[1]  = mk(0, 0, 0,  0, 0, 0,  1,  0,   0,   1,  16,          0);
    vec[2]  = mk(0, 0, 0,  0, 0, 0,  0,  0,   0,   0,  16,          0);
    vec[3]  = mk(0, 0, 0,  1, 15,15, 0,  0,   1,   0,  16,          0);
    vec[4]  = mk(1, 1, 2,  0, 0, 0,  0,  0,   0,   1,  30,          1);
    vec[5]  = mk(1, 1, 2,  0, 0, 0,  0,  0,   0,   1,  30,          1);
    vec[6]  = mk(1, 1, 2,  0, 0, 0,  0,  0,   0,   1,  30,          1);
    vec[7]  = mk(1, 1, 2,  0, 0, 0,  0,  0,   0,   1,  30,          1);
    vec[8]  = mk(1, 1, 2,  0, 0, 0,  1,  0,   0,   1,  30,          1);
    vec[9]  = mk(1, 1, 2,  0, 0, 0,  0,  1,   0,   0,  30,          1);
    vec[10] = mk(0, 0, 0,  0, 0, 0,  1,  0,   0,   1,  3,           0);
    vec[11] = mk(1, 1, 2,  1, 3, 4,  1,  !RR, RR,  0,  3,           0);
    vec[12] = mk(1, 1, 2,  1, 3, 4,  1,  0,   0,   1,  RR ? 7 : 3,  RR);
    vec[13] = mk(1, 1, 2,  1, 3, 4,  1,  1,   0,   0,  RR ? 7 : 3,  RR);
    vec[14] = mk(0, 0, 0,  0, 0, 0,  1,  0,   0,   1,  3,           0);
    vec[15] = mk(0, 0, 0,  0, 0, 0,  0,  0,   0,   0,  3,           0);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vec[i].v0, vec[i].a0, vec[i].b0, vec[i].v1, vec[i].a1, vec[i].b1, vec[i].rr);
      #1;
      chk($sformatf("row%0d req0_ready", i), req0_ready, vec[i].r0);
      chk($sformatf("row%0d req1_ready", i), req1_ready, vec[i].r1);
      chk($sformatf("row%0d res_valid", i), res_valid, vec[i].rv);
      chk($sformatf("row%0d res_sum", i), res_sum, vec[i].sum);
      chk($sformatf("row%0d res_id", i), res_id, vec[i].id);
    end
    // Both requesters valid from a fresh reset: 0,1,0,1 with round-robin, else always 0.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int eid;
      eid = RR ? k % 2 : 0;
      @(negedge clk);
      drive(1, 1, 2, 1, 3, 4, 1);
      #1;
      chk($sformatf("dual%0d req0_ready", k), req0_ready, eid == 0);
      chk($sformatf("dual%0d req1_ready", k), req1_ready, eid == 1);
      chk($sformatf("dual%0d idle res_valid", k), res_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("dual%0d res_valid", k), res_valid, 1);
      chk($sformatf("dual%0d res_sum", k), res_sum, eid ? 7 : 3);
      chk($sformatf("dual%0d res_id", k), res_id, eid);
    end
    // Asynchronous reset in HOLD discards the result and blocks readies while low.
    @(negedge clk);
    drive(1, 7, 9, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 2, 1, 3, 4, 0);
    #1;
    chk("hold res_valid", res_valid, 1);
    chk("hold res_sum", res_sum, 16);
    #2 rst_n = 1'b0;
    #1;
    chk("arst res_valid", res_valid, 0);
    chk("arst res_sum", res_sum, 0);
    chk("arst res_id", res_id, 0);
    chk("arst req0_ready", req0_ready, 0);
    chk("arst req1_ready", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset req0_ready", req0_ready, 1);
    chk("post-reset req1_ready", req1_ready, 0);
    @(negedge clk);
    #1;
    chk("post-reset res_sum", res_sum, 3);
    chk("post-reset res_id", res_id, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
